// File: rtl/bcd_display_ctrl.sv
// Display front-end: converts a signed 32-bit result to blanked packed BCD with a
// serial double-dabble engine and holds the previous value until the new one commits.
module bcd_display_ctrl #(
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] valor,
    input  logic        load,
    output logic [31:0] segmentos,
    output logic        neg,
    output logic        ovf,
    output logic        busy,
    output logic        done
);

    localparam logic [31:0] RESET_SEG = (BLANK_LZ != 0) ? 32'h00FFFFF0 : 32'h00000000;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t      state_reg, state_next;
    logic [31:0] mag_reg;
    logic        sgn_reg;
    logic [39:0] acc_reg;
    logic [39:0] acc_adj;
    logic [4:0]  cnt_reg;
    logic [31:0] seg_reg;
    logic        neg_reg, ovf_reg, done_reg;
    logic [5:1]  upper_zero;
    logic [23:0] disp;
    logic        acc_ovf;
    logic        unused_acc_msb;

    // Digit 9 never reaches 8 for a 32-bit magnitude, so its top bit is shifted out unused.
    assign unused_acc_msb = acc_adj[39];
    assign acc_ovf        = |acc_reg[39:24];

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_adj
            assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5)
                                        ? acc_reg[gi*4 +: 4] + 4'd3
                                        : acc_reg[gi*4 +: 4];
        end

        // upper_zero[n]: digit n and every digit above it (up to 5) are zero.
        for (gi = 1; gi < 6; gi++) begin : g_lz
            if (gi == 5) begin : g_top
                assign upper_zero[gi] = (acc_reg[23:20] == 4'd0);
            end else begin : g_rest
                assign upper_zero[gi] = upper_zero[gi+1] && (acc_reg[gi*4 +: 4] == 4'd0);
            end
            assign disp[gi*4 +: 4] = ((BLANK_LZ != 0) && upper_zero[gi]) ? 4'hF
                                                                          : acc_reg[gi*4 +: 4];
        end
    endgenerate

    assign disp[3:0] = acc_reg[3:0];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load) state_next = CONV;
            CONV:    if (cnt_reg == 5'd31) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mag_reg  <= 32'd0;
            sgn_reg  <= 1'b0;
            acc_reg  <= 40'd0;
            cnt_reg  <= 5'd0;
            seg_reg  <= RESET_SEG;
            neg_reg  <= 1'b0;
            ovf_reg  <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        mag_reg <= valor[31] ? (~valor + 32'd1) : valor;
                        sgn_reg <= valor[31];
                        acc_reg <= 40'd0;
                        cnt_reg <= 5'd0;
                    end
                end
                CONV: begin
                    acc_reg <= {acc_adj[38:0], mag_reg[31]};
                    mag_reg <= {mag_reg[30:0], 1'b0};
                    cnt_reg <= cnt_reg + 5'd1;
                end
                COMMIT: begin
                    seg_reg  <= {8'h00, (acc_ovf ? 24'hFFFFFF : disp)};
                    // A zero result never shows a minus sign.
                    neg_reg  <= sgn_reg && (acc_ovf || (acc_reg != 40'd0));
                    ovf_reg  <= acc_ovf;
                    done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign segmentos = seg_reg;
    assign neg       = neg_reg;
    assign ovf       = ovf_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Random and directed conversions checked against an arithmetic decimal model,
// with both blanking settings instantiated side by side.
module tb_bcd_display_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] valor;
    logic        load;
    logic [31:0] seg1, seg0;
    logic        neg1, neg0, ovf1, ovf0, busy1, busy0, done1, done0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] prev_seg1, prev_seg0;

    always #5 clk = ~clk;

    bcd_display_ctrl #(.BLANK_LZ(1)) dut (
        .clk(clk), .rst_n(rst_n), .valor(valor), .load(load),
        .segmentos(seg1), .neg(neg1), .ovf(ovf1), .busy(busy1), .done(done1)
    );

    bcd_display_ctrl #(.BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .valor(valor), .load(load),
        .segmentos(seg0), .neg(neg0), .ovf(ovf0), .busy(busy0), .done(done0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", tag, got, exp);
    endtask

    function automatic longint magnitude(input logic [31:0] v);
        longint s;
        s = longint'($signed(v));
        return (s < 0) ? -s : s;
    endfunction

    function automatic logic [31:0] model_seg(input logic [31:0] v, input bit blank);
        longint m, p, dig;
        logic [31:0] r;
        bit seen;
        m = magnitude(v);
        if (m > 999999) return 32'h00FFFFFF;
        r = 32'd0;
        seen = 1'b0;
        p = 100000;
        for (int d = 5; d >= 0; d--) begin
            dig = (m / p) % 10;
            if (dig != 0) seen = 1'b1;
            r = r << 4;
            r[3:0] = (blank && !seen && d != 0) ? 4'hF : 4'(dig);
            p = p / 10;
        end
        return r;
    endfunction

    // Starts at a negedge with the block idle; returns at the negedge where done is high.
    task automatic convert(input logic [31:0] v, input int poke_at, input logic [31:0] poke_v);
        int  cycles;
        bit  hold_ok, done_ok;
        longint m;
        valor = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        check_eq("done_after_accept", {31'd0, done1}, 32'd0);
        cycles  = 0;
        hold_ok = 1'b1;
        done_ok = 1'b1;
        while (busy1 && cycles < 40) begin
            cycles++;
            if (seg1 !== prev_seg1 || seg0 !== prev_seg0) hold_ok = 1'b0;
            if (done1 || done0) done_ok = 1'b0;
            if (cycles == poke_at) begin
                valor = poke_v;
                load  = 1'b1;
            end
            @(negedge clk);
            load = 1'b0;
        end
        m = magnitude(v);
        check_eq("busy_cycles", 32'(cycles), 32'd33);
        check_eq("hold_during_conv", {31'd0, hold_ok}, 32'd1);
        check_eq("no_early_done", {31'd0, done_ok}, 32'd1);
        check_eq("done_pulse", {31'd0, done1}, 32'd1);
        check_eq("seg_blank", seg1, model_seg(v, 1'b1));
        check_eq("seg_noblank", seg0, model_seg(v, 1'b0));
        check_eq("neg", {31'd0, neg1}, {31'd0, (v[31] && m != 0)});
        check_eq("ovf", {31'd0, ovf1}, {31'd0, (m > 999999)});
        $display("conv valor=%0d seg=%h seg_nb=%h neg=%0b ovf=%0b", $signed(v), seg1, seg0, neg1, ovf1);
        prev_seg1 = seg1;
        prev_seg0 = seg0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_seg"}, seg1, 32'h00FFFFF0);
        check_eq({tag, "_seg_nb"}, seg0, 32'h00000000);
        check_eq({tag, "_flags"}, {28'd0, neg1, ovf1, busy1, done1}, 32'd0);
        prev_seg1 = 32'h00FFFFF0;
        prev_seg0 = 32'h00000000;
    endtask

    initial begin
        logic [31:0] v;
        int          dcount;
        rst_n = 1'b0;
        load  = 1'b0;
        valor = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_reset_state("reset");

        convert(32'd123, 0, 32'd0);
        convert(-32'sd45, 0, 32'd0);
        convert(32'd0, 0, 32'd0);
        convert(32'd999999, 0, 32'd0);
        convert(32'd1000000, 0, 32'd0);
        convert(32'h80000000, 0, 32'd0);
        convert(-32'sd999999, 0, 32'd0);
        convert(32'd7, 10, 32'd8);
        @(negedge clk);
        check_eq("single_done", {31'd0, done1}, 32'd0);
        check_eq("ignored_load_idle", {31'd0, busy1}, 32'd0);

        for (int i = 0; i < 24; i++) begin
            case (i % 4)
                0: v = $urandom;
                1: v = 32'($urandom_range(0, 999999));
                2: v = -32'($urandom_range(0, 999999));
                default: v = 32'($urandom_range(999990, 1000010)) * (($urandom_range(0, 1) != 0) ? 32'd1 : 32'hFFFFFFFF);
            endcase
            convert(v, 0, 32'd0);
        end

        @(negedge clk);
        valor = 32'd555;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        dcount = 0;
        repeat (14) begin
            if (done1) dcount++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_state("abort");
        repeat (40) begin
            if (done1 || busy1) dcount++;
            @(negedge clk);
        end
        check_eq("abort_no_done", 32'(dcount), 32'd0);
        convert(32'd42, 0, 32'd0);
        check_eq("after_abort", seg1, 32'h00FFFF42);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
